axi3_sram_slave: RTL and testbench

AXI3 responder backed by a word-addressed on-chip memory, the slave-side counterpart of the core's 32-bit AXI master port. It is the memory model the top-level bench attaches to the core's `ar/r/aw/w/b` channels, and the basis for a synthesizable scratchpad. Read and write paths are independent state machines. Each path accepts one transaction at a time and supports FIXED, INCR and WRAP bursts of 32-bit beats.

---
 rtl/axi3_sram_slave_if.sv | 67 ++++++
 rtl/axi3_sram_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_axi3_sram_slave.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi3_sram_slave_if.sv
// rtl/axi3_sram_slave_if.sv - AXI3 address/data/response channel bundle for the SRAM slave
// Ports: ar/r read channels, aw/w/b write channels; slave modport faces the memory,
// master modport faces the requester. Clock and reset are not part of the bundle.
interface axi3_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi3_sram_slave.sv
// rtl/axi3_sram_slave.sv - AXI3 responder over a word-addressed on-chip memory
// Ports: aclk, aresetn (async active-low), bus (axi3_sram_slave_if.slave: ar/r/aw/w/b).
// Read and write paths are independent FSMs sharing only the memory array.
module axi3_sram_slave #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi3_sram_slave_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [31:0] mem_q [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return {1'b0, off} < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    function automatic logic burst_err(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'd2) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size != 3'd2) || (burst == 2'd3) || bad_wrap || !in_range(addr);
    endfunction

    // For legal WRAP lengths (len+1 a power of two) the window mask is len*4+3.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = {22'd0, len, 2'b11};
        case (burst)
            2'd0:    return addr;
            2'd2:    return (addr & ~mask) | ((addr + 32'd4) & mask);
            default: return addr + 32'd4;
        endcase
    endfunction

    // Read path
    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q, r_id_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]  r_burst_q, r_burst_d;
    logic        r_err_q, r_err_d;
    logic [31:0] r_data_q, r_data_d;
    logic [1:0]  r_resp_q, r_resp_d;
    logic        r_last_q, r_last_d;
    logic        r_load;
    logic [31:0] r_load_addr;

    always_comb begin
        r_state_d   = r_state_q;
        r_id_d      = r_id_q;
        r_addr_d    = r_addr_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_burst_d   = r_burst_q;
        r_err_d     = r_err_q;
        r_data_d    = r_data_q;
        r_resp_d    = r_resp_q;
        r_last_d    = r_last_q;
        r_load      = 1'b0;
        r_load_addr = r_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_state_d   = R_DATA;
                    r_id_d      = bus.arid;
                    r_len_d     = bus.arlen;
                    r_burst_d   = bus.arburst;
                    r_err_d     = burst_err(bus.araddr, bus.arlen, bus.arsize, bus.arburst);
                    r_cnt_d     = 8'd0;
                    r_last_d    = (bus.arlen == 8'd0);
                    r_load      = 1'b1;
                    r_load_addr = bus.araddr;
                end
            end
            default: begin
                if (bus.rready) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                        r_last_d  = 1'b0;
                    end else begin
                        r_cnt_d     = r_cnt_q + 8'd1;
                        r_last_d    = (r_cnt_d == r_len_q);
                        r_load      = 1'b1;
                        r_load_addr = next_addr(r_addr_q, r_len_q, r_burst_q);
                    end
                end
            end
        endcase
        // Beat data is fetched one cycle ahead so rdata leaves a register;
        // a same-cycle write lands after this read, so the old word is returned.
        if (r_load) begin
            r_addr_d = r_load_addr;
            if (r_err_d || !in_range(r_load_addr)) begin
                r_data_d = 32'd0;
                r_resp_d = 2'b10;
            end else begin
                r_data_d = mem_q[word_idx(r_load_addr)];
                r_resp_d = 2'b00;
            end
        end
    end

    // Write path
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_id_q, w_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]  w_burst_q, w_burst_d;
    logic        w_err_q, w_err_d;
    logic        w_slv_q, w_slv_d;
    logic [1:0]  w_bresp_q, w_bresp_d;
    logic        w_final;
    logic        mem_we;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_slv_d   = w_slv_q;
        w_bresp_d = w_bresp_q;
        w_final   = (w_cnt_q == w_len_q);
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid) begin
                    w_state_d = W_DATA;
                    w_id_d    = bus.awid;
                    w_addr_d  = bus.awaddr;
                    w_len_d   = bus.awlen;
                    w_burst_d = bus.awburst;
                    w_err_d   = burst_err(bus.awaddr, bus.awlen, bus.awsize, bus.awburst);
                    w_slv_d   = w_err_d;
                    w_cnt_d   = 8'd0;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    mem_we   = !w_err_q && in_range(w_addr_q);
                    // Dropped beats and a misplaced wlast both poison the response.
                    w_slv_d  = w_slv_q || !mem_we || (bus.wlast != w_final);
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_final) begin
                        w_state_d = W_RESP;
                        w_bresp_d = w_slv_d ? 2'b10 : 2'b00;
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem_q[word_idx(w_addr_q)][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            r_id_q    <= 4'd0;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_burst_q <= 2'd0;
            r_err_q   <= 1'b0;
            r_data_q  <= 32'd0;
            r_resp_q  <= 2'd0;
            r_last_q  <= 1'b0;
            w_state_q <= W_IDLE;
            w_id_q    <= 4'd0;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_burst_q <= 2'd0;
            w_err_q   <= 1'b0;
            w_slv_q   <= 1'b0;
            w_bresp_q <= 2'd0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_slv_q   <= w_slv_d;
            w_bresp_q <= w_bresp_d;
        end
    end

    assign bus.arready = (r_state_q == R_IDLE);
    assign bus.rvalid  = (r_state_q == R_DATA);
    assign bus.rid     = r_id_q;
    assign bus.rdata   = r_data_q;
    assign bus.rresp   = r_resp_q;
    assign bus.rlast   = r_last_q;
    assign bus.awready = (w_state_q == W_IDLE);
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bid     = w_id_q;
    assign bus.bresp   = w_bresp_q;

    logic unused_ok;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid};
endmodule

// File: tb/tb_axi3_sram_slave.sv
// tb/tb_axi3_sram_slave.sv - self-checking bench for axi3_sram_slave against a burst-level memory model
module tb_axi3_sram_slave;
    localparam logic [31:0] BASE  = 32'h0;
    localparam longint      BYTES = 4 * 4096;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axi3_sram_slave_if bus ();

    axi3_sram_slave #(.MEM_WORDS(4096), .BASE_ADDR(BASE)) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] mm [int];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_range(input logic [31:0] b);
        return (longint'(b) >= longint'(BASE)) && (longint'(b) < longint'(BASE) + BYTES);
    endfunction

    function automatic bit m_burst_err(input logic [31:0] a, input int len, input int size, input int burst);
        bit wrap_bad;
        wrap_bad = (burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15);
        return (size != 2) || (burst == 3) || wrap_bad || !m_in_range(a);
    endfunction

    function automatic logic [31:0] m_beat(input logic [31:0] a, input int len, input int burst, input int k);
        longint sz, base;
        if (burst == 0) return a;
        if (burst == 2) begin
            sz   = longint'(len + 1) * 4;
            base = longint'(a) - (longint'(a) % sz);
            return 32'(base + ((longint'(a) - base + 4 * k) % sz));
        end
        return 32'(longint'(a) + 4 * k);
    endfunction

    function automatic int m_idx(input logic [31:0] b);
        return int'((longint'(b) - longint'(BASE)) / 4);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input int burst, input bit bad_wlast);
        bit slv;
        int n;
        logic [31:0] b, old;
        slv = m_burst_err(a, len, size, burst) || bad_wlast;
        bus.awid = id; bus.awaddr = a; bus.awlen = 8'(len);
        bus.awsize = 3'(size); bus.awburst = 2'(burst); bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        chk("aw_handshake_timeout", 32'(n < 100), 32'd1);
        @(negedge aclk);
        bus.awvalid = 1'b0;
        chk("wready_after_aw", 32'(bus.wready), 32'd1);
        for (int k = 0; k <= len; k++) begin
            b = m_beat(a, len, burst, k);
            bus.wdata = wd[k]; bus.wstrb = ws[k];
            bus.wlast = (k == len) && !bad_wlast;
            bus.wvalid = 1'b1;
            n = 0;
            while (bus.wready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
            chk("w_beat_timeout", 32'(n < 100), 32'd1);
            @(negedge aclk);
            if (!m_burst_err(a, len, size, burst) && m_in_range(b)) begin
                old = mm.exists(m_idx(b)) ? mm[m_idx(b)] : 32'd0;
                for (int i = 0; i < 4; i++)
                    if (ws[k][i]) old[8*i +: 8] = wd[k][8*i +: 8];
                mm[m_idx(b)] = old;
            end else begin
                slv = 1'b1;
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("bvalid_after_last_w", 32'(bus.bvalid), 32'd1);
        chk("bid", 32'(bus.bid), 32'(id));
        chk("bresp", 32'(bus.bresp), slv ? 32'd2 : 32'd0);
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        chk("awready_after_b", 32'(bus.awready), 32'd1);
    endtask

    // rmode: 0 = rready held high, 1 = toggling (starts low), 2 = random
    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len,
                           input int size, input int burst, input int rmode);
        bit err_b, e, hs;
        int n, beat;
        logic [31:0] b;
        err_b = m_burst_err(a, len, size, burst);
        bus.arid = id; bus.araddr = a; bus.arlen = 8'(len);
        bus.arsize = 3'(size); bus.arburst = 2'(burst); bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 100) begin @(negedge aclk); n++; end
        chk("ar_handshake_timeout", 32'(n < 100), 32'd1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        chk("rvalid_latency", 32'(bus.rvalid), 32'd1);
        beat = 0; n = 0;
        while (beat <= len && n < 2000) begin
            b = m_beat(a, len, burst, beat);
            e = err_b || !m_in_range(b);
            chk("rvalid", 32'(bus.rvalid), 32'd1);
            chk("rid", 32'(bus.rid), 32'(id));
            chk("rdata", bus.rdata, e ? 32'd0 : (mm.exists(m_idx(b)) ? mm[m_idx(b)] : 32'hxxxxxxxx));
            chk("rresp", 32'(bus.rresp), e ? 32'd2 : 32'd0);
            chk("rlast", 32'(bus.rlast), 32'(beat == len));
            case (rmode)
                0: bus.rready = 1'b1;
                1: bus.rready = (n % 2 == 1);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            hs = bus.rready;
            @(negedge aclk);
            n++;
            if (hs) beat++;
        end
        bus.rready = 1'b0;
        chk("r_burst_timeout", 32'(n < 2000), 32'd1);
        chk("rvalid_after_burst", 32'(bus.rvalid), 32'd0);
        chk("arready_after_burst", 32'(bus.arready), 32'd1);
    endtask

    task automatic chk_reset_values();
        chk("rst_arready", 32'(bus.arready), 32'd1);
        chk("rst_awready", 32'(bus.awready), 32'd1);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd0);
        chk("rst_rid", 32'(bus.rid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rresp", 32'(bus.rresp), 32'd0);
        chk("rst_bid", 32'(bus.bid), 32'd0);
        chk("rst_bresp", 32'(bus.bresp), 32'd0);
    endtask

    initial begin
        int burst, len;
        logic [31:0] addr;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0; bus.bready = 0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk_reset_values();
        aresetn = 1'b1;
        @(negedge aclk);

        // W data offered before any AW must be ignored
        bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        @(negedge aclk);
        chk("wready_before_aw", 32'(bus.wready), 32'd0);
        @(negedge aclk);
        chk("bvalid_before_aw", 32'(bus.bvalid), 32'd0);
        bus.wvalid = 1'b0; bus.wlast = 1'b0;

        // Single write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'h1, 32'h100, 0, 2, 1, 1'b0);
        do_read(4'h2, 32'h100, 0, 2, 1, 0);

        // INCR burst, read back with toggling rready
        for (int k = 0; k < 8; k++) begin wd[k] = 32'(k); ws[k] = 4'hF; end
        do_write(4'h3, 32'h200, 7, 2, 1, 1'b0);
        do_read(4'h4, 32'h200, 7, 2, 1, 1);

        // WRAP read starting mid-window
        wd[0] = 32'hAAAA0001; wd[1] = 32'hBBBB0002; wd[2] = 32'hCCCC0003; wd[3] = 32'hDDDD0004;
        for (int k = 0; k < 4; k++) ws[k] = 4'hF;
        do_write(4'h5, 32'h10, 3, 2, 1, 1'b0);
        do_read(4'h6, 32'h1C, 3, 2, 2, 0);

        // Byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'h7, 32'h40, 0, 2, 1, 1'b0);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'h8, 32'h40, 0, 2, 1, 1'b0);
        do_read(4'h9, 32'h40, 0, 2, 1, 0);

        // Errors: out-of-range read, narrow write, illegal wrap length
        do_read(4'hA, 32'h4000, 3, 2, 1, 2);
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(4'hB, 32'h40, 0, 1, 1, 1'b0);
        do_read(4'hC, 32'h40, 0, 2, 1, 0);
        do_read(4'hD, 32'h10, 2, 2, 2, 0);

        // INCR running off the top of memory, and a write with wlast missing
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'hE, 32'h3FF8, 3, 2, 1, 1'b0);
        do_read(4'hF, 32'h3FF8, 3, 2, 1, 2);
        for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'h1, 32'h300, 1, 2, 1, 1'b1);
        do_read(4'h2, 32'h300, 1, 2, 1, 0);

        // Randomised bursts over a pre-filled region
        for (int k = 0; k < 256; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(4'h3, 32'h1000, 255, 2, 1, 1'b0);
        for (int it = 0; it < 16; it++) begin
            burst = $urandom_range(0, 2);
            if (burst == 2) begin
                case ($urandom_range(0, 3))
                    0: len = 1;
                    1: len = 3;
                    2: len = 7;
                    default: len = 15;
                endcase
            end else begin
                len = $urandom_range(0, 15);
            end
            addr = 32'h1000 + 32'(4 * $urandom_range(0, 239));
            for (int k = 0; k <= len; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
            do_write(4'($urandom_range(0, 15)), addr, len, 2, burst, 1'b0);
            do_read(4'($urandom_range(0, 15)), addr, len, 2, burst, 2);
        end

        // Concurrent read and write bursts
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        fork
            do_write(4'h5, 32'h600, 3, 2, 1, 1'b0);
            do_read(4'h9, 32'h200, 7, 2, 1, 2);
        join
        do_read(4'h6, 32'h600, 3, 2, 1, 0);

        // Reset in the middle of a read burst
        bus.arid = 4'h3; bus.araddr = 32'h200; bus.arlen = 8'd7;
        bus.arsize = 3'd2; bus.arburst = 2'd1; bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (2) @(negedge aclk);
        chk("midburst_rvalid", 32'(bus.rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk_reset_values();
        @(negedge aclk);
        aresetn = 1'b1; bus.rready = 1'b0;
        #1;
        chk("arready_after_reset", 32'(bus.arready), 32'd1);
        @(negedge aclk);
        do_read(4'h7, 32'h200, 1, 2, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
